// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the program/data RAM arbiter
//                and the reusable 2-way picker.
//                - arb_state_e : arbiter FSM encoding (IDLE/ISSUE/WAIT/ACK)
//                - OWN_CPU / OWN_DBG : owner ids. They double as the bit index
//                  of each requester in the picker's req vector.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      ACK   = 2'd3
   } arb_state_e;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DBG = 1'b1;

   // Read latency is limited to 1..4, so RD_LAT-1 always fits in 2 bits.
   localparam int LAT_CNT_W = 2;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Combinational 2-way picker. A lone request always wins. On a
//                tie, fixed priority gives the win to requester 0 (CPU);
//                otherwise the requester that was not granted last wins.
//  Ports       : req[1:0] (bit0 = CPU, bit1 = DBG), last (owner of the most
//                recent grant), prio_en (1 = fixed priority), gnt (owner id)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   input  logic       prio_en,
   output logic       gnt
);

   always_comb begin
      gnt = OWN_CPU;
      case (req)
         2'b01:   gnt = OWN_CPU;
         2'b10:   gnt = OWN_DBG;
         // Owner ids are 1-bit, so "the other port" is simply ~last.
         2'b11:   gnt = prio_en ? OWN_CPU : ~last;
         default: gnt = OWN_CPU;
      endcase
   end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one single-port synchronous RAM between the CPU memory
//                interface and the debug/loader port. One access at a time;
//                each access is IDLE -> ISSUE -> (WAIT x RD_LAT) -> ACK, with
//                writes skipping WAIT.
//  Ports       : clk, reset_n (asynchronous, active-high)
//                cpu_*  : CPU request/we/addr/wdata in, ack/rdata out
//                dbg_*  : debug request/we/addr/wdata in, ack/rdata out
//                mem_*  : RAM en/we/addr/wdata out, rdata in
//                busy   : any state other than IDLE
//                cpu_stall : cpu_req & ~cpu_ack
//  Params      : ADDR_W, DATA_W, RD_LAT (1..4), CPU_PRIO (1 = CPU wins ties)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W   = 9,
   parameter int DATA_W   = 32,
   parameter int RD_LAT   = 1,
   parameter int CPU_PRIO = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_ack,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              cpu_stall
);

   localparam logic                 PRIO_EN  = (CPU_PRIO != 0) ? 1'b1 : 1'b0;
   localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(RD_LAT - 1);

   arb_state_e           state_q, state_d;
   logic                 owner_q, owner_d;
   logic                 last_grant_q, last_grant_d;
   logic                 we_q, we_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [DATA_W-1:0]    wdata_q, wdata_d;
   logic [LAT_CNT_W-1:0] lat_cnt_q, lat_cnt_d;
   logic [DATA_W-1:0]    cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0]    dbg_rdata_q, dbg_rdata_d;
   logic                 gnt;

   rr_arbiter2 u_rr_arbiter2 (
      .req     ({dbg_req, cpu_req}),
      .last    (last_grant_q),
      .prio_en (PRIO_EN),
      .gnt     (gnt)
   );

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      lat_cnt_d    = lat_cnt_q;
      cpu_rdata_d  = cpu_rdata_q;
      dbg_rdata_d  = dbg_rdata_q;

      case (state_q)
         IDLE: begin
            // Requests are only looked at here; whatever arrives later waits
            // for the next return to IDLE.
            if (cpu_req || dbg_req) begin
               owner_d = gnt;
               if (gnt == OWN_DBG) begin
                  we_d    = dbg_we;
                  addr_d  = dbg_addr;
                  wdata_d = dbg_wdata;
               end else begin
                  we_d    = cpu_we;
                  addr_d  = cpu_addr;
                  wdata_d = cpu_wdata;
               end
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (we_q) begin
               state_d = ACK;
            end else begin
               lat_cnt_d = LAT_INIT;
               state_d   = WAIT;
            end
         end
         WAIT: begin
            if (lat_cnt_q == '0) begin
               if (owner_q == OWN_DBG) begin
                  dbg_rdata_d = mem_rdata;
               end else begin
                  cpu_rdata_d = mem_rdata;
               end
               state_d = ACK;
            end else begin
               lat_cnt_d = lat_cnt_q - 1'b1;
            end
         end
         ACK: begin
            last_grant_d = owner_q;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         state_q      <= IDLE;
         owner_q      <= OWN_CPU;
         last_grant_q <= OWN_DBG;   // CPU wins the first tie after reset
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         lat_cnt_q    <= '0;
         cpu_rdata_q  <= '0;
         dbg_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         lat_cnt_q    <= lat_cnt_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dbg_rdata_q  <= dbg_rdata_d;
      end
   end

   // All outputs decode from registered state, so an asserted reset clears
   // them immediately without waiting for a clock edge.
   always_comb begin
      mem_en    = (state_q == ISSUE);
      mem_we    = (state_q == ISSUE) && we_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      cpu_ack   = (state_q == ACK) && (owner_q == OWN_CPU);
      dbg_ack   = (state_q == ACK) && (owner_q == OWN_DBG);
      busy      = (state_q != IDLE);
      cpu_rdata = cpu_rdata_q;
      dbg_rdata = dbg_rdata_q;
      // Masked by reset so every output reads 0 while reset is held.
      cpu_stall = cpu_req && !cpu_ack && !reset_n;
   end

endmodule : mem_arbiter
`default_nettype wire
